display_mode_ctrl: RTL and testbench

Sequences the 16-bit two-input display multiplexer that selects between reaction-timer and pulse-monitor results for the seven-segment driver. It synchronizes and debounces the mode slide switch and defers a mode change while a reaction test is in progress. It blanks the display for a fixed window around each switch-over and drives the mux select. An optional auto-scan feature alternates the two displays periodically.

---
 rtl/display_mode_ctrl.sv | 164 ++++++++++++++++
 tb/tb_display_mode_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_mode_ctrl.sv
// Mode sequencer for the reaction-timer / pulse-monitor display mux: switch sync + debounce,
// busy deferral, blanking around switch-overs. Optional auto-scan under `AUTO_SCAN_EN.
module display_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int BLANK_CYCLES    = 1000,
    parameter int SCAN_PERIOD     = 200000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_mode,
    input  logic rt_busy,
`ifdef AUTO_SCAN_EN
    input  logic auto_scan,
`endif
    output logic mode,
    output logic blank,
    output logic mode_changed
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int BLK_W = $clog2(BLANK_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || BLANK_CYCLES < 1 || SCAN_PERIOD < 2) begin : g_bad_params
        $error("display_mode_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {SHOW, WAIT, BLANK} state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d, sync2_q, sync2_d;
    logic             deb_q, deb_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             mode_q, mode_d, next_q, next_d;
    logic             blank_q, blank_d, mode_changed_q, mode_changed_d;
    logic             target;

`ifdef AUTO_SCAN_EN
    localparam int SCAN_W = $clog2(SCAN_PERIOD);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_PERIOD - 1);

    logic              scan_on_q, scan_on_d, scan_tgt_q, scan_tgt_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;

    // scan_on_q is the registered auto_scan, so the scan target is valid before it is used
    assign target = scan_on_q ? scan_tgt_q : deb_q;

    always_comb begin
        scan_on_d  = auto_scan;
        scan_tgt_d = scan_tgt_q;
        scan_cnt_d = scan_cnt_q;
        if (auto_scan && !scan_on_q) begin
            scan_tgt_d = mode_q;
            scan_cnt_d = '0;
        end else if (auto_scan) begin
            if (scan_cnt_q == SCAN_LAST) begin
                scan_cnt_d = '0;
                scan_tgt_d = ~scan_tgt_q;
            end else begin
                scan_cnt_d = scan_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_on_q  <= 1'b0;
            scan_tgt_q <= 1'b0;
            scan_cnt_q <= '0;
        end else begin
            scan_on_q  <= scan_on_d;
            scan_tgt_q <= scan_tgt_d;
            scan_cnt_q <= scan_cnt_d;
        end
    end
`else
    assign target = deb_q;
`endif

    always_comb begin
        sync1_d        = sw_mode;
        sync2_d        = sync1_q;
        deb_d          = deb_q;
        deb_cnt_d      = deb_cnt_q;
        state_d        = state_q;
        blk_cnt_d      = blk_cnt_q;
        mode_d         = mode_q;
        next_d         = next_q;
        blank_d        = blank_q;
        mode_changed_d = 1'b0;

        if (sync2_q == deb_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            deb_d     = sync2_q;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end

        case (state_q)
            SHOW, WAIT: begin
                if (target == mode_q) begin
                    state_d = SHOW;
                end else if (!mode_q && rt_busy) begin
                    // leaving the reaction timer mid-test would hide its result
                    state_d = WAIT;
                end else begin
                    next_d    = target;
                    blk_cnt_d = '0;
                    blank_d   = 1'b1;
                    state_d   = BLANK;
                end
            end
            BLANK: begin
                if (blk_cnt_q == BLK_LAST) begin
                    mode_d         = next_q;
                    mode_changed_d = 1'b1;
                    blank_d        = 1'b0;
                    state_d        = SHOW;
                end else begin
                    blk_cnt_d = blk_cnt_q + 1'b1;
                end
            end
            default: begin
                blank_d = 1'b0;
                state_d = SHOW;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            deb_q          <= 1'b0;
            deb_cnt_q      <= '0;
            state_q        <= SHOW;
            blk_cnt_q      <= '0;
            mode_q         <= 1'b0;
            next_q         <= 1'b0;
            blank_q        <= 1'b0;
            mode_changed_q <= 1'b0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            deb_q          <= deb_d;
            deb_cnt_q      <= deb_cnt_d;
            state_q        <= state_d;
            blk_cnt_q      <= blk_cnt_d;
            mode_q         <= mode_d;
            next_q         <= next_d;
            blank_q        <= blank_d;
            mode_changed_q <= mode_changed_d;
        end
    end

    assign mode         = mode_q;
    assign blank        = blank_q;
    assign mode_changed = mode_changed_q;

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Randomized self-checking bench for display_mode_ctrl against a timing-rule reference model.
// Exercises the auto-scan scenario only when AUTO_SCAN_EN is defined.
module tb_display_mode_ctrl;

    localparam int D = 4;
    localparam int B = 3;
    localparam int P = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sw_mode = 1'b0;
    logic rt_busy = 1'b0;
    logic auto_scan = 1'b0;
    logic mode, blank, mode_changed;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    display_mode_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .BLANK_CYCLES(B),
        .SCAN_PERIOD(P)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw_mode(sw_mode),
        .rt_busy(rt_busy),
`ifdef AUTO_SCAN_EN
        .auto_scan(auto_scan),
`endif
        .mode(mode),
        .blank(blank),
        .mode_changed(mode_changed)
    );

    // Reference model: switch value seen two edges late, accepted after D consecutive
    // disagreeing samples; a switch-over is a B-cycle blanking countdown ending in the new mode.
    bit m_hist[$];
    bit m_deb, m_mode, m_next, m_changed, m_scan_on, m_scan_tgt;
    int m_run, m_blank_left, m_scan_ticks;

    function automatic void model_reset();
        m_hist = '{1'b0, 1'b0};
        m_deb = 0; m_mode = 0; m_next = 0; m_changed = 0;
        m_scan_on = 0; m_scan_tgt = 0;
        m_run = 0; m_blank_left = 0; m_scan_ticks = 0;
    endfunction

    function automatic void model_step(bit sw, bit busy, bit auto_in);
        bit tgt, sync, old_mode;
        old_mode = m_mode;
        tgt  = m_scan_on ? m_scan_tgt : m_deb;
        sync = m_hist[0];
        m_hist.push_back(sw);
        void'(m_hist.pop_front());
        m_changed = 0;
        if (m_blank_left > 0) begin
            m_blank_left--;
            if (m_blank_left == 0) begin
                m_mode = m_next;
                m_changed = 1;
            end
        end else if (tgt != m_mode && !(m_mode == 0 && busy)) begin
            m_next = tgt;
            m_blank_left = B;
        end
        if (sync != m_deb) begin
            m_run++;
            if (m_run == D) begin
                m_deb = sync;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        if (auto_in && !m_scan_on) begin
            m_scan_tgt = old_mode;
            m_scan_ticks = 0;
        end else if (auto_in) begin
            m_scan_ticks++;
            if (m_scan_ticks == P) begin
                m_scan_ticks = 0;
                m_scan_tgt = !m_scan_tgt;
            end
        end
        m_scan_on = auto_in;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(sw_mode, rt_busy, auto_scan);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int pulses, blanks;
        sw_mode = 1'b1; rt_busy = 1'b0; auto_scan = 1'b0;
        model_reset();
        #3;
        n_checks++; if (mode !== 1'b0) $display("FAIL reset_mode got %b want 0", mode); else n_pass++;
        n_checks++; if (blank !== 1'b0) $display("FAIL reset_blank got %b want 0", blank); else n_pass++;
        n_checks++; if (mode_changed !== 1'b0) $display("FAIL reset_chg got %b want 0", mode_changed); else n_pass++;
        tick(); tick();
        rst_n = 1'b1;
        pulses = 0; blanks = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            pulses += int'(mode_changed);
            blanks += int'(blank);
            n_checks++;
            if ({mode, blank, mode_changed} !== {m_mode, m_blank_left > 0, m_changed})
                $display("FAIL reset_seq cyc %0d got mbc=%b%b%b want %b%b%b", i, mode, blank,
                         mode_changed, m_mode, m_blank_left > 0, m_changed);
            else n_pass++;
        end
        n_checks++; if (mode !== 1'b1) $display("FAIL reset_final_mode got %b want 1", mode); else n_pass++;
        n_checks++; if (pulses != 1) $display("FAIL reset_pulses got %0d want 1", pulses); else n_pass++;
        n_checks++; if (blanks != B) $display("FAIL reset_blanks got %0d want %0d", blanks, B); else n_pass++;
    endtask

    task automatic test_glitch();
        int blanks;
        sw_mode = 1'b0; rt_busy = 1'b0;
        do_reset();
        blanks = 0;
        for (int i = 0; i < 31; i++) begin
            sw_mode = (i >= 8 && i < 11);
            tick();
            blanks += int'(blank);
            n_checks++;
            if ({mode, blank, mode_changed} !== {m_mode, m_blank_left > 0, m_changed})
                $display("FAIL glitch_seq cyc %0d got mbc=%b%b%b want %b%b%b", i, mode, blank,
                         mode_changed, m_mode, m_blank_left > 0, m_changed);
            else n_pass++;
        end
        n_checks++; if (blanks != 0) $display("FAIL glitch_blanks got %0d want 0", blanks); else n_pass++;
        n_checks++; if (mode !== 1'b0) $display("FAIL glitch_mode got %b want 0", mode); else n_pass++;
    endtask

    task automatic test_busy_defer();
        int blanks;
        sw_mode = 1'b0; rt_busy = 1'b1;
        do_reset();
        sw_mode = 1'b1;
        blanks = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            blanks += int'(blank) + int'(mode);
        end
        n_checks++; if (blanks != 0) $display("FAIL defer_held got %0d blank/mode cycles want 0", blanks); else n_pass++;
        rt_busy = 1'b0;
        tick();
        n_checks++; if (blank !== 1'b1) $display("FAIL defer_blank_rise got %b want 1", blank); else n_pass++;
        tick(); tick();
        n_checks++; if ({blank, mode} !== 2'b10) $display("FAIL defer_blank_hold got bm=%b%b want 10", blank, mode); else n_pass++;
        tick();
        n_checks++;
        if ({mode, blank, mode_changed} !== 3'b101)
            $display("FAIL defer_switch got mbc=%b%b%b want 101", mode, blank, mode_changed);
        else n_pass++;
        tick();
        n_checks++; if (mode_changed !== 1'b0) $display("FAIL defer_pulse_len got %b want 0", mode_changed); else n_pass++;
    endtask

    task automatic test_withdraw();
        int events;
        sw_mode = 1'b0; rt_busy = 1'b1;
        do_reset();
        events = 0;
        for (int i = 0; i < 50; i++) begin
            sw_mode = (i < 20);
            if (i >= 40) rt_busy = 1'b0;
            tick();
            events += int'(blank) + int'(mode_changed);
            n_checks++;
            if ({mode, blank, mode_changed} !== {m_mode, m_blank_left > 0, m_changed})
                $display("FAIL withdraw_seq cyc %0d got mbc=%b%b%b want %b%b%b", i, mode, blank,
                         mode_changed, m_mode, m_blank_left > 0, m_changed);
            else n_pass++;
        end
        n_checks++; if (events != 0) $display("FAIL withdraw_events got %0d want 0", events); else n_pass++;
    endtask

    task automatic test_revert();
        int pulses, blanks, guard;
        sw_mode = 1'b0; rt_busy = 1'b0;
        do_reset();
        sw_mode = 1'b1;
        pulses = 0; blanks = 0; guard = 0;
        while (blank !== 1'b1 && guard < 30) begin
            tick();
            guard++;
        end
        n_checks++; if (blank !== 1'b1) $display("FAIL revert_timeout got blank=%b want 1", blank); else n_pass++;
        sw_mode = 1'b0;
        blanks = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            pulses += int'(mode_changed);
            blanks += int'(blank);
            n_checks++;
            if ({mode, blank, mode_changed} !== {m_mode, m_blank_left > 0, m_changed})
                $display("FAIL revert_seq cyc %0d got mbc=%b%b%b want %b%b%b", i, mode, blank,
                         mode_changed, m_mode, m_blank_left > 0, m_changed);
            else n_pass++;
        end
        n_checks++; if (pulses != 2) $display("FAIL revert_pulses got %0d want 2", pulses); else n_pass++;
        n_checks++; if (blanks != 2 * B) $display("FAIL revert_blanks got %0d want %0d", blanks, 2 * B); else n_pass++;
        n_checks++; if (mode !== 1'b0) $display("FAIL revert_mode got %b want 0", mode); else n_pass++;
    endtask

    task automatic test_random();
        int sw_hold, busy_hold;
        sw_mode = 1'b0; rt_busy = 1'b0;
        do_reset();
        sw_hold = 0; busy_hold = 0;
        for (int i = 0; i < 800; i++) begin
            if (sw_hold == 0) begin
                sw_mode = $urandom_range(0, 1);
                sw_hold = $urandom_range(1, 14);
            end
            if (busy_hold == 0) begin
                rt_busy = $urandom_range(0, 1);
                busy_hold = $urandom_range(1, 25);
            end
            sw_hold--; busy_hold--;
            tick();
            n_checks++;
            if ({mode, blank, mode_changed} !== {m_mode, m_blank_left > 0, m_changed})
                $display("FAIL random_seq cyc %0d got mbc=%b%b%b want %b%b%b", i, mode, blank,
                         mode_changed, m_mode, m_blank_left > 0, m_changed);
            else n_pass++;
        end
    endtask

`ifdef AUTO_SCAN_EN
    task automatic test_auto_scan();
        int pulses, guard;
        sw_mode = 1'b0; rt_busy = 1'b0;
        do_reset();
        auto_scan = 1'b1;
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            sw_mode = $urandom_range(0, 1);
            tick();
            pulses += int'(mode_changed);
            n_checks++;
            if ({mode, blank, mode_changed} !== {m_mode, m_blank_left > 0, m_changed})
                $display("FAIL scan_seq cyc %0d got mbc=%b%b%b want %b%b%b", i, mode, blank,
                         mode_changed, m_mode, m_blank_left > 0, m_changed);
            else n_pass++;
        end
        n_checks++; if (pulses < 8) $display("FAIL scan_pulses got %0d want >=8", pulses); else n_pass++;
        guard = 0;
        while (!(blank === 1'b1 && mode === 1'b1) && guard < 60) begin
            tick();
            guard++;
        end
        n_checks++; if ({blank, mode} !== 2'b11) $display("FAIL scan_wait_blank got bm=%b%b want 11", blank, mode); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({mode, blank, mode_changed} !== 3'b000)
            $display("FAIL scan_midblank_reset got mbc=%b%b%b want 000", mode, blank, mode_changed);
        else n_pass++;
        auto_scan = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_glitch();
        test_busy_defer();
        test_withdraw();
        test_revert();
        test_random();
`ifdef AUTO_SCAN_EN
        test_auto_scan();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
